// File: rtl/instr_fetch_seq_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM encoding, datapath widths and the instr reset value.
package instr_fetch_seq_pkg;

    localparam int PC_W    = 4;
    localparam int INSTR_W = 32;

    localparam logic [INSTR_W-1:0] INSTR_RST = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_HOLD      = 3'd2,
        ST_WAIT_STEP = 3'd3,
        ST_HALT      = 3'd4
    } state_t;

    // Next program index after a transfer; only used when the run continues.
    function automatic logic [PC_W-1:0] pc_advance(
        input logic [PC_W-1:0] pc_cur,
        input logic [PC_W-1:0] last_pc
    );
        if (pc_cur == last_pc) begin
            return {PC_W{1'b0}};
        end else begin
            return pc_cur + {{(PC_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/instr_fetch_seq.sv
// Walks an external instruction ROM and hands each word downstream with a
// valid/ready handshake; supports free-run, single-step and wrap-around.
module instr_fetch_seq
    import instr_fetch_seq_pkg::*;
#(
    parameter int unsigned LAST_ADDR = 15,
    parameter bit          WRAP_EN   = 1'b0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               step_mode,
    input  logic               step,
    input  logic [INSTR_W-1:0] rom_data,
    input  logic               out_ready,
    output logic [PC_W-1:0]    rom_sel,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [PC_W-1:0]    pc,
    output logic               busy,
    output logic               done
);

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(LAST_ADDR);

    state_t             state_r;
    logic [PC_W-1:0]    pc_r;
    logic [INSTR_W-1:0] instr_r;
    logic               instr_valid_r;
    logic               busy_r;
    logic               done_r;
    logic               xfer_s;
    logic               at_last_s;

    assign xfer_s    = instr_valid_r & out_ready;
    assign at_last_s = (pc_r == LAST_PC);

    // Sequencer FSM; busy/done are registered alongside the state they decode.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            pc_r          <= {PC_W{1'b0}};
            instr_r       <= INSTR_RST;
            instr_valid_r <= 1'b0;
            busy_r        <= 1'b0;
            done_r        <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        pc_r    <= {PC_W{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    instr_r       <= rom_data;
                    instr_valid_r <= 1'b1;
                    state_r       <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (xfer_s) begin
                        instr_valid_r <= 1'b0;
                        if (at_last_s && !WRAP_EN) begin
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            state_r <= ST_HALT;
                        end else begin
                            pc_r    <= pc_advance(pc_r, LAST_PC);
                            state_r <= step_mode ? ST_WAIT_STEP : ST_FETCH;
                        end
                    end
                end
                ST_WAIT_STEP: begin
                    if (step) begin
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    state_r <= ST_HALT;
                end
                default: begin
                    state_r       <= ST_IDLE;
                    pc_r          <= {PC_W{1'b0}};
                    instr_valid_r <= 1'b0;
                    busy_r        <= 1'b0;
                    done_r        <= 1'b0;
                end
            endcase
        end
    end

    assign rom_sel     = pc_r;
    assign pc          = pc_r;
    assign instr       = instr_r;
    assign instr_valid = instr_valid_r;
    assign busy        = busy_r;
    assign done        = done_r;

endmodule

// File: tb/tb_instr_fetch_seq.sv
// Bench for instr_fetch_seq: a default (halting) and a wrapping instance share
// stimulus; a behavioural model plus directed literal expectations check them.
module tb_instr_fetch_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, start, step_mode, step, out_ready;
    logic [3:0]  rom_sel0, pc0, rom_sel1, pc1;
    logic [31:0] rom_data0, rom_data1, instr0, instr1;
    logic        valid0, busy0, done0, valid1, busy1, done1;

    // ROM model: word = C0DE0000 + index
    assign rom_data0 = 32'hC0DE_0000 + {28'h0, rom_sel0};
    assign rom_data1 = 32'hC0DE_0000 + {28'h0, rom_sel1};

    instr_fetch_seq u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .rom_data(rom_data0), .out_ready(out_ready), .rom_sel(rom_sel0), .instr(instr0),
        .instr_valid(valid0), .pc(pc0), .busy(busy0), .done(done0)
    );

    instr_fetch_seq #(.LAST_ADDR(5), .WRAP_EN(1'b1)) u_wrap (
        .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
        .rom_data(rom_data1), .out_ready(out_ready), .rom_sel(rom_sel1), .instr(instr1),
        .instr_valid(valid1), .pc(pc1), .busy(busy1), .done(done1)
    );

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    int last_a [2] = '{15, 5};
    bit wrap_a [2] = '{1'b0, 1'b1};

    // Model: what each instance must show, tracked as run/fetch/wait flags
    logic [3:0]  m_pc    [2];
    logic [31:0] m_instr [2];
    bit          m_valid [2];
    bit          m_busy  [2];
    bit          m_done  [2];
    bit          m_fetch [2];
    bit          m_wait  [2];
    int          m_cnt   [2];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        if (!rst_n) begin
            m_pc[i] = 4'd0; m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_busy[i] = 1'b0;
            m_done[i] = 1'b0; m_fetch[i] = 1'b0; m_wait[i] = 1'b0; m_cnt[i] = 0;
        end else if (!m_busy[i] && !m_done[i]) begin
            if (start) begin
                m_pc[i] = 4'd0; m_busy[i] = 1'b1; m_fetch[i] = 1'b1; m_cnt[i] = 0;
            end
        end else if (m_done[i]) begin
            m_done[i] = 1'b1;
        end else if (m_fetch[i]) begin
            m_instr[i] = 32'hC0DE_0000 + {28'h0, m_pc[i]};
            m_valid[i] = 1'b1;
            m_fetch[i] = 1'b0;
        end else if (m_valid[i]) begin
            if (out_ready) begin
                m_valid[i] = 1'b0;
                m_cnt[i]++;
                if (int'(m_pc[i]) == last_a[i] && !wrap_a[i]) begin
                    m_done[i] = 1'b1; m_busy[i] = 1'b0;
                end else begin
                    m_pc[i] = (int'(m_pc[i]) == last_a[i]) ? 4'd0 : m_pc[i] + 4'd1;
                    if (step_mode) m_wait[i] = 1'b1;
                    else           m_fetch[i] = 1'b1;
                end
            end
        end else if (m_wait[i]) begin
            if (step) begin
                m_wait[i] = 1'b0; m_fetch[i] = 1'b1;
            end
        end
    endtask

    task automatic cmp_one(input int i, input logic [3:0] d_pc, input logic [3:0] d_sel,
                           input logic [31:0] d_instr, input logic d_valid,
                           input logic d_busy, input logic d_done);
        int idx;
        check($sformatf("u%0d_pc", i), d_pc, m_pc[i]);
        check($sformatf("u%0d_rom_sel", i), d_sel, m_pc[i]);
        check($sformatf("u%0d_instr", i), d_instr, m_instr[i]);
        check($sformatf("u%0d_valid", i), d_valid, m_valid[i]);
        check($sformatf("u%0d_busy", i), d_busy, m_busy[i]);
        check($sformatf("u%0d_done", i), d_done, m_done[i]);
        // Transferred word must be the next one in program order
        if (d_valid && out_ready) begin
            idx = wrap_a[i] ? (m_cnt[i] % (last_a[i] + 1)) : m_cnt[i];
            check($sformatf("u%0d_xfer_word", i), d_instr, 32'hC0DE_0000 + idx);
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin
            m_pc[i] = 4'd0; m_instr[i] = 32'h0; m_valid[i] = 1'b0; m_busy[i] = 1'b0;
            m_done[i] = 1'b0; m_fetch[i] = 1'b0; m_wait[i] = 1'b0; m_cnt[i] = 0;
        end
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) model_step(i);
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                cmp_one(0, pc0, rom_sel0, instr0, valid0, busy0, done0);
                cmp_one(1, pc1, rom_sel1, instr1, valid1, busy1, done1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; out_ready = 1'b0;
        tick();
        tick();
        cmp_en = 1'b1;
        check("rst_pc", pc0, 4'd0);
        check("rst_instr", instr0, 32'h0);
        check("rst_valid", valid0, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_done", done0, 1'b0);

        // Free-run, with spurious step held high and a start pulse mid-run
        rst_n = 1'b1; out_ready = 1'b1; step = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 16; w++) begin
            tick();
            check("fr_instr", instr0, 32'hC0DE_0000 + w);
            check("fr_pc", pc0, w);
            check("fr_valid", valid0, 1'b1);
            check("fr_done_early", done0, 1'b0);
            check("wrap_pc", pc1, w % 6);
            check("wrap_instr", instr1, 32'hC0DE_0000 + (w % 6));
            check("wrap_done", done1, 1'b0);
            if (w == 5) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("fr_done", done0, 1'b1);
        check("fr_busy_halt", busy0, 1'b0);
        check("fr_valid_halt", valid0, 1'b0);
        check("fr_pc_halt", pc0, 4'd15);
        step = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("halt_sticky", done0, 1'b1);

        // Backpressure at pc=3
        do_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 3; w++) begin tick(); tick(); end
        out_ready = 1'b0;
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_instr", instr0, 32'hC0DE_0003);
            check("bp_valid", valid0, 1'b1);
            check("bp_pc", pc0, 4'd3);
            tick();
        end
        out_ready = 1'b1;
        check("bp_pc_release", pc0, 4'd3);
        tick();
        check("bp_pc_next", pc0, 4'd4);
        check("bp_valid_next", valid0, 1'b0);
        tick();
        check("bp_instr_next", instr0, 32'hC0DE_0004);

        // Single-step
        do_reset();
        step_mode = 1'b1; start = 1'b1; step = 1'b1;
        tick();
        start = 1'b0; step = 1'b0;
        tick();
        check("ss_word0", instr0, 32'hC0DE_0000);
        tick();
        for (int k = 0; k < 10; k++) begin
            check("ss_wait_valid", valid0, 1'b0);
            check("ss_wait_busy", busy0, 1'b1);
            tick();
        end
        for (int s = 1; s <= 3; s++) begin
            step = 1'b1;
            tick();
            step = 1'b0;
            tick();
            check("ss_instr", instr0, 32'hC0DE_0000 + s);
            check("ss_pc", pc0, s);
            tick();
        end

        // Reset while holding the word at pc=7; start during reset is ignored
        do_reset();
        step_mode = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        for (int w = 0; w < 7; w++) begin tick(); tick(); end
        out_ready = 1'b0;
        tick();
        check("mr_pc7", pc0, 4'd7);
        rst_n = 1'b0; start = 1'b1;
        tick();
        check("mr_valid", valid0, 1'b0);
        check("mr_pc", pc0, 4'd0);
        check("mr_busy", busy0, 1'b0);
        check("mr_instr", instr0, 32'h0);
        tick();
        rst_n = 1'b1; start = 1'b0;
        tick();
        check("mr_idle", busy0, 1'b0);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            rst_n     = ($urandom_range(0, 199) != 0);
            start     = ($urandom_range(0, 7) == 0);
            step      = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 9) < 7);
            if ($urandom_range(0, 15) == 0) step_mode = ~step_mode;
            tick();
        end

        tick();
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
